// File: rtl/easyaxi_rd_slv_pkg.sv
// Shared EasyAXI channel widths, encodings and helpers used by the read slave
// and reused by the write slave.
package easyaxi_rd_slv_pkg;

    localparam int AXI_ID_W    = 4;
    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'd1;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'd2;

    localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'd2;
    localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'd3;

    localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_4B = 3'd2;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } rd_state_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]    id;
        logic [AXI_ADDR_W-1:0]  addr;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
    } ar_entry_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic axi_wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/easyaxi_burst_addr.sv
// Combinational next-beat address generator for FIXED, INCR and WRAP bursts.
module easyaxi_burst_addr
    import easyaxi_rd_slv_pkg::*;
(
    input  logic [AXI_ADDR_W-1:0]  addr,
    input  logic [AXI_LEN_W-1:0]   len,
    input  logic [AXI_SIZE_W-1:0]  size,
    input  logic [AXI_BURST_W-1:0] burst,
    output logic [AXI_ADDR_W-1:0]  next_addr
);

    logic [AXI_ADDR_W-1:0] bytes;
    logic [AXI_ADDR_W-1:0] incr_addr;
    logic [AXI_ADDR_W-1:0] wrap_mask;

    // The wrap window is the whole burst footprint; the high part of the
    // address is held while the low part advances modulo that window.
    always_comb begin
        bytes     = AXI_ADDR_W'(1) << size;
        incr_addr = addr + bytes;
        wrap_mask = (bytes * (AXI_ADDR_W'(len) + AXI_ADDR_W'(1))) - AXI_ADDR_W'(1);
        next_addr = addr;
        case (burst)
            AXI_BURST_INCR: next_addr = incr_addr;
            AXI_BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:        next_addr = addr;
        endcase
    end

endmodule

// File: rtl/easyaxi_rd_slv.sv
// AXI read slave: buffers AR requests in a circular FIFO and streams R beats
// in request order from a synthetic read-only memory.
module easyaxi_rd_slv
    import easyaxi_rd_slv_pkg::*;
#(
    parameter int                    OST_DEPTH = 16,
    parameter int                    MEM_WORDS = 64,
    parameter logic [AXI_DATA_W-1:0] DATA_SEED = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   axi_slv_arvalid,
    output logic                   axi_slv_arready,
    input  logic [AXI_ID_W-1:0]    axi_slv_arid,
    input  logic [AXI_ADDR_W-1:0]  axi_slv_araddr,
    input  logic [AXI_LEN_W-1:0]   axi_slv_arlen,
    input  logic [AXI_SIZE_W-1:0]  axi_slv_arsize,
    input  logic [AXI_BURST_W-1:0] axi_slv_arburst,
    output logic                   axi_slv_rvalid,
    input  logic                   axi_slv_rready,
    output logic [AXI_ID_W-1:0]    axi_slv_rid,
    output logic [AXI_DATA_W-1:0]  axi_slv_rdata,
    output logic [AXI_RESP_W-1:0]  axi_slv_rresp,
    output logic                   axi_slv_rlast
);

    localparam int              PTR_W      = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam int              WORD_SHIFT = $clog2(AXI_DATA_W / 8);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(OST_DEPTH - 1);

    ar_entry_t             ost_q [OST_DEPTH];
    ar_entry_t             push_entry;
    ar_entry_t             head;
    logic [OST_DEPTH-1:0]  ost_vld_q;
    logic [PTR_W-1:0]      set_ptr_q;
    logic [PTR_W-1:0]      clr_ptr_q;
    logic                  head_vld;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  beat_last;
    logic                  slverr;
    logic                  decerr;
    rd_state_e             state_q;
    rd_state_e             state_d;
    logic [AXI_ADDR_W-1:0] beat_addr_q;
    logic [AXI_ADDR_W-1:0] beat_addr_d;
    logic [AXI_ADDR_W-1:0] beat_addr;
    logic [AXI_ADDR_W-1:0] next_addr;
    logic [AXI_ADDR_W-1:0] word_idx;
    logic [AXI_LEN_W-1:0]  beat_cnt_q;
    logic [AXI_LEN_W-1:0]  beat_cnt_d;
    logic [AXI_LEN_W-1:0]  beat_cnt;

    // Ready comes only from the slot valid bit, so a pop never bypasses into a full buffer.
    assign axi_slv_arready = ~ost_vld_q[set_ptr_q];
    assign ar_hs           = axi_slv_arvalid & axi_slv_arready;
    assign head            = ost_q[clr_ptr_q];
    assign head_vld        = ost_vld_q[clr_ptr_q];
    assign r_hs            = head_vld & axi_slv_rready;

    always_comb begin
        push_entry.id    = axi_slv_arid;
        push_entry.addr  = axi_slv_araddr;
        push_entry.len   = axi_slv_arlen;
        push_entry.size  = axi_slv_arsize;
        push_entry.burst = axi_slv_arburst;
    end

    always_ff @(posedge clk) begin
        if (ar_hs) begin
            ost_q[set_ptr_q] <= push_entry;
        end
    end

    // Push and pop always hit different slots, so both updates can land together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ost_vld_q <= '0;
            set_ptr_q <= '0;
            clr_ptr_q <= '0;
        end else begin
            if (ar_hs) begin
                ost_vld_q[set_ptr_q] <= 1'b1;
                set_ptr_q            <= (set_ptr_q == PTR_LAST) ? '0 : set_ptr_q + 1'b1;
            end
            if (r_hs && beat_last) begin
                ost_vld_q[clr_ptr_q] <= 1'b0;
                clr_ptr_q            <= (clr_ptr_q == PTR_LAST) ? '0 : clr_ptr_q + 1'b1;
            end
        end
    end

    // In IDLE the head entry is presented directly as beat 0, which hides the load cycle.
    assign beat_addr = (state_q == ST_BURST) ? beat_addr_q : head.addr;
    assign beat_cnt  = (state_q == ST_BURST) ? beat_cnt_q : '0;
    assign beat_last = (beat_cnt == head.len);

    easyaxi_burst_addr u_burst_addr (
        .addr      (beat_addr),
        .len       (head.len),
        .size      (head.size),
        .burst     (head.burst),
        .next_addr (next_addr)
    );

    always_comb begin
        state_d     = state_q;
        beat_addr_d = beat_addr_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (r_hs && beat_last) begin
                    state_d = ST_IDLE;
                end else if (r_hs) begin
                    state_d     = ST_BURST;
                    beat_addr_d = next_addr;
                    beat_cnt_d  = AXI_LEN_W'(1);
                end else if (head_vld) begin
                    state_d     = ST_BURST;
                    beat_addr_d = head.addr;
                    beat_cnt_d  = '0;
                end
            end
            ST_BURST: begin
                if (r_hs && beat_last) begin
                    state_d = ST_IDLE;
                end else if (r_hs) begin
                    beat_addr_d = next_addr;
                    beat_cnt_d  = beat_cnt_q + AXI_LEN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_addr_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_addr_q <= beat_addr_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign word_idx = beat_addr >> WORD_SHIFT;
    assign slverr   = (head.size > AXI_SIZE_W'(WORD_SHIFT)) ||
                      ((head.burst == AXI_BURST_WRAP) && !axi_wrap_len_ok(head.len));
    assign decerr   = (word_idx >= AXI_ADDR_W'(MEM_WORDS));

    // Outputs are forced to their idle values whenever no beat is offered.
    always_comb begin
        axi_slv_rvalid = head_vld;
        axi_slv_rid    = '0;
        axi_slv_rdata  = '0;
        axi_slv_rresp  = AXI_RESP_OKAY;
        axi_slv_rlast  = 1'b0;
        if (head_vld) begin
            axi_slv_rid   = head.id;
            axi_slv_rlast = beat_last;
            if (slverr) begin
                axi_slv_rresp = AXI_RESP_SLVERR;
            end else if (decerr) begin
                axi_slv_rresp = AXI_RESP_DECERR;
            end else begin
                axi_slv_rdata = AXI_DATA_W'(word_idx) ^ DATA_SEED;
            end
        end
    end

endmodule

// File: tb/tb_easyaxi_rd_slv.sv
// Directed bench for easyaxi_rd_slv; expected R beats are queued at AR time
// and popped by a monitor as beats are accepted.
module tb_easyaxi_rd_slv;
    import easyaxi_rd_slv_pkg::*;

    localparam int                    OST   = 4;
    localparam int                    WORDS = 64;
    localparam logic [AXI_DATA_W-1:0] SEED  = '0;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_RESP_W-1:0] resp;
        logic                  last;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   arvalid;
    logic                   arready;
    logic [AXI_ID_W-1:0]    arid;
    logic [AXI_ADDR_W-1:0]  araddr;
    logic [AXI_LEN_W-1:0]   arlen;
    logic [AXI_SIZE_W-1:0]  arsize;
    logic [AXI_BURST_W-1:0] arburst;
    logic                   rvalid;
    logic                   rready;
    logic [AXI_ID_W-1:0]    rid;
    logic [AXI_DATA_W-1:0]  rdata;
    logic [AXI_RESP_W-1:0]  rresp;
    logic                   rlast;

    beat_t exp_q[$];
    beat_t mon_exp;
    int    n_cmp = 0;
    int    n_bad = 0;

    easyaxi_rd_slv #(
        .OST_DEPTH (OST),
        .MEM_WORDS (WORDS),
        .DATA_SEED (SEED)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axi_slv_arvalid (arvalid),
        .axi_slv_arready (arready),
        .axi_slv_arid    (arid),
        .axi_slv_araddr  (araddr),
        .axi_slv_arlen   (arlen),
        .axi_slv_arsize  (arsize),
        .axi_slv_arburst (arburst),
        .axi_slv_rvalid  (rvalid),
        .axi_slv_rready  (rready),
        .axi_slv_rid     (rid),
        .axi_slv_rdata   (rdata),
        .axi_slv_rresp   (rresp),
        .axi_slv_rlast   (rlast)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference beat sequence, written with modulo arithmetic on the wrap window.
    task automatic push_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        logic [31:0] bytes;
        logic [31:0] wb;
        logic [31:0] lo;
        beat_t       b;
        a     = addr;
        bytes = 32'd1 << size;
        wb    = bytes * (32'(len) + 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            b.id   = id;
            b.last = (i == int'(len));
            if (size > 3'd2 || (burst == AXI_BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})))
                b.resp = AXI_RESP_SLVERR;
            else if ((a / 32'd4) >= 32'(WORDS))
                b.resp = AXI_RESP_DECERR;
            else
                b.resp = AXI_RESP_OKAY;
            b.data = (b.resp == AXI_RESP_OKAY) ? ((a / 32'd4) ^ SEED) : 32'd0;
            exp_q.push_back(b);
            if (burst == AXI_BURST_INCR) begin
                a = a + bytes;
            end else if (burst == AXI_BURST_WRAP) begin
                lo = a - (a % wb);
                a  = lo + ((a - lo + bytes) % wb);
            end
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
        int n;
        arvalid = 1'b1;
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        push_burst(id, addr, len, size, burst);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arready && n < 50);
        check_output("ar_accepted", 64'(arready), 64'd1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_output({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        check_output({tag, "_idle"}, 64'(rvalid), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_beat", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_output("rid", 64'(rid), 64'(mon_exp.id));
                check_output("rdata", 64'(rdata), 64'(mon_exp.data));
                check_output("rresp", 64'(rresp), 64'(mon_exp.resp));
                check_output("rlast", 64'(rlast), 64'(mon_exp.last));
            end
        end
    end

    initial begin
        int waits;
        rst_n   = 1'b0;
        arvalid = 1'b0;
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        rready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_arready", 64'(arready), 64'd1);
        check_output("rst_rvalid", 64'(rvalid), 64'd0);
        check_output("rst_rlast", 64'(rlast), 64'd0);
        check_output("rst_rid", 64'(rid), 64'd0);
        check_output("rst_rresp", 64'(rresp), 64'(AXI_RESP_OKAY));
        check_output("rst_rdata", 64'(rdata), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] INCR burst");
        rready = 1'b1;
        apply_stimulus(4'd0, 32'h00, 8'd3, AXI_SIZE_4B, AXI_BURST_INCR);
        check_output("incr_first_rvalid", 64'(rvalid), 64'd1);
        drain("incr");

        $display("[TB] WRAP bursts back to back");
        apply_stimulus(4'd1, 32'h34, 8'd3, AXI_SIZE_4B, AXI_BURST_WRAP);
        apply_stimulus(4'd2, 32'h38, 8'd2, AXI_SIZE_4B, AXI_BURST_WRAP);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_output("turnaround_rvalid", 64'(rvalid), (i < 5) ? 64'd1 : 64'd0);
        end
        drain("wrap");

        $display("[TB] FIXED, DECERR and oversize bursts");
        apply_stimulus(4'd3, 32'h30, 8'd3, AXI_SIZE_4B, AXI_BURST_FIXED);
        drain("fixed");
        apply_stimulus(4'd4, 32'hFC, 8'd1, AXI_SIZE_4B, AXI_BURST_INCR);
        drain("decerr");
        apply_stimulus(4'd5, 32'h08, 8'd0, 3'd3, AXI_BURST_INCR);
        drain("oversize");

        $display("[TB] full buffer");
        rready = 1'b0;
        for (int i = 0; i < 4; i++)
            apply_stimulus(4'(8 + i), 32'h40 + 32'(i * 16), 8'd1, AXI_SIZE_4B, AXI_BURST_INCR);
        arvalid = 1'b1;
        arid    = 4'd12;
        araddr  = 32'h80;
        arlen   = 8'd1;
        arsize  = AXI_SIZE_4B;
        arburst = AXI_BURST_INCR;
        push_burst(4'd12, 32'h80, 8'd1, AXI_SIZE_4B, AXI_BURST_INCR);
        repeat (3) begin
            @(negedge clk);
            check_output("full_arready", 64'(arready), 64'd0);
            check_output("stall_rdata", 64'(rdata), 64'h10);
        end
        @(posedge clk);
        #1;
        rready = 1'b1;
        waits  = 0;
        @(negedge clk);
        while (!arready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        check_output("full_accept_delay", 64'(waits), 64'd2);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        drain("full");

        $display("[TB] reset mid-burst");
        apply_stimulus(4'd6, 32'h00, 8'd7, AXI_SIZE_4B, AXI_BURST_INCR);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("pre_rst_rdata", 64'(rdata), 64'd2);
        rst_n = 1'b0;
        #1;
        check_output("midrst_rvalid", 64'(rvalid), 64'd0);
        check_output("midrst_arready", 64'(arready), 64'd1);
        check_output("midrst_rlast", 64'(rlast), 64'd0);
        check_output("midrst_rdata", 64'(rdata), 64'd0);
        check_output("midrst_rid", 64'(rid), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(4'd7, 32'h10, 8'd1, AXI_SIZE_4B, AXI_BURST_INCR);
        check_output("post_rst_rdata", 64'(rdata), 64'd4);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/easyaxi_rd_slv.md
# easyaxi_rd_slv

AXI read slave. It accepts AR requests into an outstanding buffer, generates per-beat addresses for FIXED, INCR and WRAP bursts, and returns R beats in request order from an internal read-only data model. It is the responder end of the AXI read channel pair and connects directly to the AR/R ports of the EasyAXI read master in the S01 testbench top.

## Interface
- `OST_DEPTH`, 16: outstanding AR entries. Power of 2, ≥1.
- `MEM_WORDS`, 64: addressable data words. Word size is `AXI_DATA_W/8` bytes.
- `DATA_SEED`, 0: value XORed into the returned data pattern.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `axi_slv_arvalid` in 1: AR valid.
- `axi_slv_arready` out 1: AR ready.
- `axi_slv_arid` in `AXI_ID_W`: AR ID.
- `axi_slv_araddr` in `AXI_ADDR_W`: AR start byte address.
- `axi_slv_arlen` in `AXI_LEN_W`: AR burst length, beats−1.
- `axi_slv_arsize` in `AXI_SIZE_W`: AR beat size, log2 bytes.
- `axi_slv_arburst` in `AXI_BURST_W`: FIXED/INCR/WRAP.
- `axi_slv_rvalid` out 1: R valid.
- `axi_slv_rready` in 1: R ready.
- `axi_slv_rid` out `AXI_ID_W`: R ID, the stored ARID.
- `axi_slv_rdata` out `AXI_DATA_W`: R data.
- `axi_slv_rresp` out `AXI_RESP_W`: OKAY/SLVERR/DECERR.
- `axi_slv_rlast` out 1: last beat of the burst.

## Operation
- **AR buffer:** circular FIFO with set pointer, clear pointer and a valid bit per entry. Each entry stores id, addr, len, size and burst.
  - `arready = ~full`. It depends only on registered state, never on `arvalid`.
  - The AR handshake writes the entry at the set pointer, then advances the pointer with wrap OST_DEPTH−1 → 0.
- **R engine:** serves the entry at the clear pointer.
  - State `IDLE` → `BURST` when the head entry is valid.
  - On entry to `BURST`, load the beat address from the stored addr and clear the beat counter.
  - Each R handshake increments the beat counter and updates the address.
  - An R handshake with `rlast` clears the head valid bit, advances the clear pointer, and goes to `IDLE`.
- **Beat address:** let `bytes = 1<<size` and `wrap_bytes = bytes*(len+1)`.
  - FIXED: address is unchanged.
  - INCR: `addr + bytes`. The address is truncated to `AXI_ADDR_W`; overflow wraps silently.
  - WRAP: `(addr & ~(wrap_bytes−1)) | ((addr + bytes) & (wrap_bytes−1))`.
- **Response per beat:**
  - SLVERR if `bytes > AXI_DATA_W/8`, or if the burst is WRAP with len ∉ {1,3,7,15}.
  - Otherwise DECERR if word index `addr/(AXI_DATA_W/8) ≥ MEM_WORDS`.
  - Otherwise OKAY.
  - Priority: SLVERR > DECERR > OKAY.
  - The burst always completes with `len+1` beats, whatever the response.
- **Data:**
  - OKAY: `rdata` = word index zero-extended, XOR `DATA_SEED`.
  - Error: `rdata` = 0.
  - Narrow transfers return the full word; byte-lane placement is the master's concern.
- **Outputs:**
  - `rid` = stored id.
  - `rlast` = (beat counter == len).
- **Reset:** all entries invalid, pointers 0, state `IDLE`. Reset values: `arready`=1, `rvalid`=0, `rlast`=0, `rid`=0, `rresp`=OKAY, `rdata`=0.

## Timing
- AR handshake at edge T: entry valid after T. The earliest `rvalid` is in cycle T+1, provided the buffer was empty and the engine idle.
- Throughput: one beat per cycle while `rready`=1.
- Burst turnaround: the last beat of burst N at edge T means the first beat of burst N+1 is in cycle T+1. There are no bubbles beyond the `IDLE` load cycle, which overlaps with that T+1 cycle.
  - Implementation: `BURST` may reload directly from the next head entry instead of passing through `IDLE`.
- R signals are stable while `rvalid`=1 and `rready`=0. `rvalid` never drops without a handshake.
- Full buffer with a simultaneous pop: `arready` stays 0 in that cycle. There is no bypass.
- Push and pop in the same cycle at different entries are both honoured.
- Reset asserted mid-burst: the outstanding burst is discarded and all outputs return to their reset values asynchronously.

## Structure
- The `AXI_*_W` widths, `AXI_BURST_*` and `AXI_RESP_*` encodings, and `AXI_SIZE_*` come from the shared EasyAXI define file. Add no local copies.
- Add `AXI_WRAP_LEN_OK(len)` to the shared file for reuse by the write slave.
- One sub-module, `easyaxi_burst_addr`: purely combinational next-beat-address generator. Inputs: addr, len, size, burst. Output: next addr.

## Test plan
- **INCR:** AR id=0, addr 0x00, len 3, size 4B, INCR, with `rready`=1 → rdata 0,1,2,3, OKAY, `rlast` on beat 4, first beat one cycle after AR.
- **WRAP:** AR addr 0x34, len 3, size 4B → beat addresses 0x34, 0x38, 0x3C, 0x30, rdata 0xD, 0xE, 0xF, 0xC. AR addr 0x38, len 2, WRAP → SLVERR on 3 beats.
- **FIXED:** AR addr 0x30, len 3 → rdata 0xC four times, `rlast` on beat 4.
- **Full buffer:** OST_DEPTH=4, `rready`=0, 5 back-to-back ARs → 4 accepted, `arready` low. When `rready` goes high, the 5th is accepted in the cycle after the first burst completes, and R order matches AR order.
- **DECERR:** MEM_WORDS=64, AR addr 0xFC, len 1, INCR → beat 0 OKAY with data 0x3F, beat 1 DECERR with data 0, `rlast` on beat 1.
- **Reset mid-burst:** `rst_n` low during beat 2 of a len-7 burst → `rvalid`=0 and `arready`=1 immediately. A new AR after reset is served from beat 0.
